// File: rtl/baud_tick_gen.sv
// Runtime-programmable terminal-count timer: periodic or one-shot tick every div+1 cycles.
// Divisor writes made while running are held pending and applied at the next terminal count.
module baud_tick_gen #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned DIV_RESET = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_WIDTH-1:0] i_div,
    input  logic                 i_div_wr,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_load_val,
    input  logic                 i_oneshot,
    input  logic                 i_stop,
    output logic                 o_tick,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] div_act_q, div_act_d;
    logic [CNT_WIDTH-1:0] pend_q, pend_d;
    logic                 pend_vld_q, pend_vld_d;
    logic                 oneshot_q, oneshot_d;
    logic [CNT_WIDTH-1:0] div_eff;
    logic                 tick;

    assign tick   = (state_q == StRun) && (cnt_q == div_act_q);
    assign o_tick = tick;
    assign o_busy = (state_q == StRun);
    assign o_cnt  = cnt_q;

    // Divisor used for the start-phase clamp: a same-cycle write takes priority.
    assign div_eff = i_div_wr ? i_div : div_act_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        oneshot_d  = oneshot_q;

        if (i_start) begin
            state_d    = StRun;
            oneshot_d  = i_oneshot;
            cnt_d      = (i_load_val > div_eff) ? div_eff : i_load_val;
            pend_vld_d = 1'b0;
            if (i_div_wr) begin
                div_act_d = i_div;
            end
        end else if (i_stop) begin
            state_d    = StIdle;
            cnt_d      = '0;
            pend_vld_d = 1'b0;
            if (i_div_wr && (state_q == StIdle)) begin
                div_act_d = i_div;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (i_div_wr) begin
                        div_act_d = i_div;
                    end
                end
                StRun: begin
                    if (tick) begin
                        cnt_d = '0;
                        if (pend_vld_q) begin
                            div_act_d  = pend_q;
                            pend_vld_d = 1'b0;
                        end
                        if (oneshot_q) begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                    // A write in the tick cycle lands in pending and waits for the next tick.
                    if (i_div_wr) begin
                        pend_d     = i_div;
                        pend_vld_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_act_q  <= CNT_WIDTH'(DIV_RESET);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            oneshot_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            oneshot_q  <= oneshot_d;
        end
    end

endmodule
